// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: steps an external single-position shifter once
// per clock to shift by 0..2^CNT_W-1 positions, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; dout holds the last result
// RUN   | one shifter step per clock, cnt counts remaining steps
// DONE  | one-cycle result strobe; a start here is accepted back-to-back
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sh_b,
  output logic [1:0]       sh_op,
  input  logic [WIDTH-1:0] sh_res,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       op_q, op_q_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      op_q  <= 2'b00;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      op_q  <= op_q_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    op_q_n  = op_q;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          acc_n  = din;
          op_q_n = op;
          cnt_n  = amount;
          // zero amount or pass-through needs no shifter steps
          if (amount == '0 || op == 2'b00) state_n = DONE;
          else                             state_n = RUN;
        end else if (state == DONE) begin
          state_n = IDLE;
        end
      end
      RUN: begin
        acc_n = sh_res;
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign sh_b  = acc;
  assign sh_op = (state == RUN) ? op_q : 2'b00;
  assign dout  = acc;
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: a behavioural one-bit shifter closes the
// loop; expected results are queued at stimulus time and popped on done.
module tb_shift_sequencer;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  typedef struct {
    logic [WIDTH-1:0] dout;
    int               nbusy;
    string            name;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] sh_b;
  logic [1:0]       sh_op;
  logic [WIDTH-1:0] sh_res;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   busy_cnt = 0;

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .amount (amount),
    .din    (din),
    .sh_b   (sh_b),
    .sh_op  (sh_op),
    .sh_res (sh_res),
    .busy   (busy),
    .done   (done),
    .dout   (dout)
  );

  // single-position shifter datapath
  always_comb begin
    case (sh_op)
      2'b01:   sh_res = {sh_b[WIDTH-2:0], 1'b0};
      2'b10:   sh_res = {1'b0, sh_b[WIDTH-1:1]};
      2'b11:   sh_res = {sh_b[WIDTH-1], sh_b[WIDTH-1:1]};
      default: sh_res = sh_b;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // monitor: count busy cycles, compare on every done
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check({e.name, "_dout"}, 32'(dout), 32'(e.dout));
            check({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(e.nbusy));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] d, input logic [1:0] o,
                       input logic [CNT_W-1:0] a);
    start  = 1'b1;
    din    = d;
    op     = o;
    amount = a;
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input int n, input string name);
    exp_t e;
    e.dout  = d;
    e.nbusy = n;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 40; k++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      check({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] d, input logic [1:0] o,
                        input logic [CNT_W-1:0] a, input logic [WIDTH-1:0] r,
                        input int n, input string name);
    @(negedge clk);
    issue(d, o, a);
    push(r, n, name);
    @(negedge clk);
    start = 1'b0;
    wait_drain(name);
  endtask

  initial begin
    int k;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    amount = '0;
    din    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_dout",  32'(dout),  32'd0);
    check("rst_sh_b",  32'(sh_b),  32'd0);
    check("rst_sh_op", 32'(sh_op), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(16'h0001, 2'b01, 4'd3,  16'h0008, 3,  "lsl3");
    run_op(16'h8000, 2'b11, 4'd4,  16'hF800, 4,  "asr4");
    run_op(16'h8000, 2'b10, 4'd4,  16'h0800, 4,  "lsr4");
    run_op(16'h1234, 2'b01, 4'd0,  16'h1234, 0,  "amt0");
    run_op(16'h1234, 2'b00, 4'd7,  16'h1234, 0,  "pass");
    run_op(16'hFFFF, 2'b10, 4'd15, 16'h0001, 15, "lsr15");

    // start during RUN is ignored; start in DONE chains with no idle cycle
    @(negedge clk);
    issue(16'h0003, 2'b01, 4'd5);
    push(16'h0060, 5, "lsl5");
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    issue(16'hFFFF, 2'b11, 4'd1);
    @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 20; k++) begin
      if (done) break;
      @(negedge clk);
    end
    check("b2b_reach_done", 32'(done), 32'd1);
    issue(16'h00F0, 2'b10, 4'd4);
    push(16'h000F, 4, "b2b_lsr4");
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_next", 32'(busy), 32'd1);
    wait_drain("b2b");

    // asynchronous reset two cycles into a 10-bit shift
    @(negedge clk);
    issue(16'h0001, 2'b01, 4'd10);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    check("mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy",  32'(busy),  32'd0);
    check("mid_rst_done",  32'(done),  32'd0);
    check("mid_rst_dout",  32'(dout),  32'd0);
    check("mid_rst_sh_b",  32'(sh_b),  32'd0);
    check("mid_rst_sh_op", 32'(sh_op), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("post_rst_idle_dout", 32'(dout), 32'd0);

    run_op(16'hFF00, 2'b11, 4'd2, 16'hFFC0, 2, "after_rst");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
